// File: rtl/apb_arb_pkg.sv
// Shared state encoding, default widths and packed-slice helper for apb_master_arb.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apbState_e;

  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT    = 16;

  // Low bit of requester idx's field inside a packed per-requester bus.
  function automatic int sliceLo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after rrPtr,
// searching upward and wrapping.
module rr_arbiter import apb_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] reqVec,
  input  logic [IDX_W-1:0]   rrPtr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grantIdx
);

  int bestDist;

  always_comb begin
    grant    = '0;
    grantIdx = '0;
    bestDist = NUM_REQ;
    // Closest requester above the pointer (with wrap) wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reqVec[i] && (((i + NUM_REQ - int'(rrPtr)) % NUM_REQ) < bestDist)) begin
        bestDist = (i + NUM_REQ - int'(rrPtr)) % NUM_REQ;
        grant    = '0;
        grant[i] = 1'b1;
        grantIdx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// Round-robin APB master serializing NUM_REQ requesters onto one APB slave.
// Optional ACCESS-phase timeout is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arb import apb_arb_pkg::*; #(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ADDr_WIDTH  = DEF_ADDR_WIDTH,
  parameter int Data_WIDTH  = DEF_DATA_WIDTH,
  parameter int pSTRB_WIDTH = Data_WIDTH / 8,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                           pclk,
  input  logic                           prst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDr_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*Data_WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ*pSTRB_WIDTH-1:0] req_strb,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [Data_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic                           psel,
  output logic                           penable,
  output logic                           pWRITE,
  output logic [ADDr_WIDTH-1:0]          pADDr,
  output logic [Data_WIDTH-1:0]          pWDATA,
  output logic [pSTRB_WIDTH-1:0]         pSTRB,
  input  logic                           pREADY,
  input  logic [Data_WIDTH-1:0]          pRDATA
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : gBadCfg
    $error("apb_master_arb: NUM_REQ must be 2..8 and TIMEOUT at least 1");
  end

  apbState_e              state;
  logic [IDX_W-1:0]       rrPtr;
  logic [IDX_W-1:0]       gntIdx;
  logic [IDX_W-1:0]       nextPtr;
  logic [NUM_REQ-1:0]     gntOh;
  logic [NUM_REQ-1:0]     arbGrant;
  logic [IDX_W-1:0]       arbIdx;
  logic [ADDr_WIDTH-1:0]  addrArr  [NUM_REQ];
  logic [Data_WIDTH-1:0]  wdataArr [NUM_REQ];
  logic [pSTRB_WIDTH-1:0] strbArr  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : gSlice
    assign addrArr[i]  = req_addr[sliceLo(i, ADDr_WIDTH) +: ADDr_WIDTH];
    assign wdataArr[i] = req_wdata[sliceLo(i, Data_WIDTH) +: Data_WIDTH];
    assign strbArr[i]  = req_strb[sliceLo(i, pSTRB_WIDTH) +: pSTRB_WIDTH];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) uArb (
    .reqVec   (req_valid),
    .rrPtr    (rrPtr),
    .grant    (arbGrant),
    .grantIdx (arbIdx)
  );

  assign req_ready = (state == IDLE) ? arbGrant : '0;
  assign nextPtr   = (gntIdx == IDX_W'(NUM_REQ - 1)) ? '0 : gntIdx + 1'b1;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] toCnt;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state     <= IDLE;
      rrPtr     <= '0;
      gntIdx    <= '0;
      gntOh     <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pWRITE    <= 1'b0;
      pADDr     <= '0;
      pWDATA    <= '0;
      pSTRB     <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      rsp_err   <= 1'b0;
      toCnt     <= '0;
`endif
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            gntIdx <= arbIdx;
            gntOh  <= arbGrant;
            pWRITE <= req_write[arbIdx];
            pADDr  <= addrArr[arbIdx];
            pWDATA <= wdataArr[arbIdx];
            pSTRB  <= strbArr[arbIdx];
            psel   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
          toCnt   <= '0;
`endif
        end
        ACCESS: begin
          // A ready in the limit cycle still completes normally.
          if (pREADY) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= gntOh;
            rsp_rdata <= pWRITE ? '0 : pRDATA;
            rrPtr     <= nextPtr;
            state     <= IDLE;
`ifdef APB_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (toCnt == CNT_W'(TIMEOUT - 1)) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= gntOh;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rrPtr     <= nextPtr;
            state     <= IDLE;
          end else begin
            toCnt <= toCnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: directed and random requester traffic, an APB RAM
// responder, and a round-robin / byte-memory reference model with scoreboard.
`timescale 1ns/1ps
module tb_apb_master_arb;

  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int TMO  = 16;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
  } cmd_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] rdata;
    logic          err;
    int            acceptCyc;
    int            lat;
  } exp_t;

  logic                 pclk = 1'b0;
  logic                 prst_n = 1'b1;
  logic [NREQ-1:0]      req_valid, req_ready, req_write, rsp_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ*SW-1:0]   req_strb;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err;
  logic                 psel, penable, pWRITE, pREADY;
  logic [AW-1:0]        pADDr;
  logic [DW-1:0]        pWDATA, pRDATA;
  logic [SW-1:0]        pSTRB;

  cmd_t          cmdQ [NREQ][$];
  exp_t          expQ [$];
  logic [DW-1:0] refMem [256];
  logic [DW-1:0] slvMem [256];
  int            nCmp = 0;
  int            nErr = 0;
  int            cyc = 0;
  int            ptrModel = 0;
  int            waitK = 1;
  bit            busy = 1'b0;
  bit            stuck = 1'b0;
  bit            dropMode = 1'b0;
  logic [AW-1:0] expAddr = '0;
  logic [DW+SW:0] expCtl = '0;

  apb_master_arb #(
    .NUM_REQ(NREQ), .ADDr_WIDTH(AW), .Data_WIDTH(DW), .pSTRB_WIDTH(SW), .TIMEOUT(TMO)
  ) dut (
    .pclk(pclk), .prst_n(prst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pWRITE(pWRITE), .pADDr(pADDr),
    .pWDATA(pWDATA), .pSTRB(pSTRB), .pREADY(pREADY), .pRDATA(pRDATA)
  );

  initial forever #5 pclk = ~pclk;
  initial forever begin @(posedge pclk); cyc++; end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nCmp++;
    if (act !== req) begin
      nErr++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Spec rule: first valid requester at or after the pointer, wrapping.
  function automatic logic [NREQ-1:0] rrPick(input logic [NREQ-1:0] v, input int ptr);
    logic [NREQ-1:0] g = '0;
    for (int off = 0; off < NREQ; off++)
      if (g == '0 && v[(ptr + off) % NREQ]) g[(ptr + off) % NREQ] = 1'b1;
    return g;
  endfunction

  function automatic bit anyPending();
    for (int i = 0; i < NREQ; i++) if (cmdQ[i].size() > 0) return 1'b1;
    return busy;
  endfunction

  task automatic push(input int r, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [SW-1:0] s);
    cmd_t c;
    c.wr = w; c.addr = a; c.wdata = d; c.strb = s;
    cmdQ[r].push_back(c);
  endtask

  task automatic accept(input int r);
    cmd_t c;
    exp_t e;
    bit   timedOut;
    c = cmdQ[r].pop_front();
    timedOut = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    // The slave answers in ACCESS cycle waitK+1; the limit is TMO cycles.
    timedOut = stuck || (waitK >= TMO);
`endif
    e.idx = r;
    e.acceptCyc = cyc;
    e.err = timedOut;
    e.rdata = '0;
    if (timedOut) e.lat = 2 + TMO;
    else begin
      e.lat = 3 + waitK;
      if (c.wr) begin
        for (int b = 0; b < SW; b++)
          if (c.strb[b]) refMem[c.addr][8*b +: 8] = c.wdata[8*b +: 8];
      end else e.rdata = refMem[c.addr];
    end
    expQ.push_back(e);
    busy = 1'b1;
    expAddr = c.addr;
    expCtl = {c.wr, c.wdata, c.strb};
  endtask

  task automatic step();
    logic [NREQ-1:0] expRdy;
    @(negedge pclk);
    for (int i = 0; i < NREQ; i++) begin
      if (cmdQ[i].size() > 0 && (!dropMode || $urandom_range(3) != 0)) begin
        req_valid[i] = 1'b1;
        req_write[i] = cmdQ[i][0].wr;
        req_addr[i*AW +: AW] = cmdQ[i][0].addr;
        req_wdata[i*DW +: DW] = cmdQ[i][0].wdata;
        req_strb[i*SW +: SW] = cmdQ[i][0].strb;
      end else begin
        req_valid[i] = 1'b0;
        req_addr[i*AW +: AW] = AW'($urandom);
      end
    end
    #2;
    expRdy = busy ? '0 : rrPick(req_valid, ptrModel);
    chk("grant", 64'(req_ready), 64'(expRdy));
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && req_ready[i]) accept(i);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (anyPending() && n < budget) begin step(); n++; end
    chk("drain_done", 64'(anyPending()), 64'(0));
    @(negedge pclk);
    req_valid = '0;
  endtask

  task automatic applyReset();
    @(negedge pclk);
    #3;
    prst_n = 1'b0;
    #1;
    chk("rst_apb", 64'({psel, penable, pWRITE, pADDr, pWDATA, pSTRB}), 64'(0));
    chk("rst_rsp", 64'({rsp_valid, rsp_rdata, rsp_err}), 64'(0));
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) cmdQ[i].delete();
    expQ.delete();
    busy = 1'b0;
    ptrModel = 0;
    #1;
    chk("rst_ready", 64'(req_ready), 64'(0));
    repeat (2) @(negedge pclk);
    prst_n = 1'b1;
  endtask

  // APB RAM responder with waitK wait cycles and random pREADY outside ACCESS.
  initial begin
    int accCnt;
    logic [AW+DW+SW:0] hold;
    accCnt = 0;
    hold = '0;
    pREADY = 1'b0;
    pRDATA = '0;
    forever begin
      @(posedge pclk);
      #1;
      if (psel === 1'b1 && penable === 1'b0) begin
        chk("setup_busy", 64'(busy), 64'(1));
        chk("setup_addr", 64'(pADDr), 64'(expAddr));
        chk("setup_ctl", 64'({pWRITE, pWDATA, pSTRB}), 64'(expCtl));
        hold = {pADDr, pWRITE, pWDATA, pSTRB};
        accCnt = 0;
        pREADY = 1'($urandom_range(1));
        pRDATA = $urandom;
      end else if (psel === 1'b1 && penable === 1'b1) begin
        chk("access_hold", 64'({pADDr, pWRITE, pWDATA, pSTRB}), 64'(hold));
        if (!stuck && accCnt >= waitK) begin
          pREADY = 1'b1;
          if (pWRITE) begin
            for (int b = 0; b < SW; b++)
              if (pSTRB[b]) slvMem[pADDr][8*b +: 8] = pWDATA[8*b +: 8];
            pRDATA = $urandom;
          end else pRDATA = slvMem[pADDr];
        end else begin
          pREADY = 1'b0;
          pRDATA = $urandom;
        end
        accCnt++;
      end else begin
        if (prst_n && penable !== 1'b0) chk("penable_without_psel", 64'(penable), 64'(0));
        pREADY = 1'($urandom_range(1));
        pRDATA = $urandom;
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a response pulse appears.
  initial begin
    exp_t e;
    logic [NREQ-1:0] oh;
    forever begin
      @(negedge pclk);
      #1;
      if (prst_n && rsp_valid !== '0) begin
        if (expQ.size() == 0) begin
          nCmp++;
          nErr++;
          $display("FAIL unexpected_rsp: rsp_valid=%b with nothing outstanding (cycle %0d)", rsp_valid, cyc);
        end else begin
          e = expQ.pop_front();
          oh = '0;
          oh[e.idx] = 1'b1;
          chk("rsp_valid", 64'(rsp_valid), 64'(oh));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          chk("latency", 64'(cyc - e.acceptCyc), 64'(e.lat));
          chk("bus_idle_at_rsp", 64'({psel, penable}), 64'(0));
          busy = 1'b0;
          ptrModel = (e.idx + 1) % NREQ;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
    for (int a = 0; a < 256; a++) begin refMem[a] = '0; slvMem[a] = '0; end
    applyReset();

    // Write then read back against the k=1 RAM.
    waitK = 1;
    push(0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
    push(0, 1'b0, 8'h10, 32'h0, 4'h0);
    drain(50);

    // Partial strobe merge.
    push(1, 1'b1, 8'h20, 32'h11223344, 4'hF);
    push(1, 1'b1, 8'h20, 32'hAABBCCDD, 4'b0011);
    push(1, 1'b0, 8'h20, 32'h0, 4'h0);
    drain(60);

    // Contention from reset: two requesters, four transfers each.
    applyReset();
    for (int k = 0; k < 4; k++) begin
      push(0, 1'($urandom_range(1)), AW'($urandom_range(15)), $urandom, 4'hF);
      push(1, 1'($urandom_range(1)), AW'($urandom_range(15)), $urandom, 4'hF);
    end
    drain(100);

    // Wait states.
    waitK = 3;
    push(3, 1'b1, 8'h08, 32'hCAFEF00D, 4'b1010);
    push(3, 1'b0, 8'h08, 32'h0, 4'h0);
    push(2, 1'b0, 8'h10, 32'h0, 4'h0);
    drain(80);

    // Randomized traffic with dropped requests and varying wait states.
    dropMode = 1'b1;
    for (int batch = 0; batch < 10; batch++) begin
      waitK = int'($urandom_range(3));
      for (int k = 0; k < 8; k++)
        push(int'($urandom_range(NREQ - 1)), 1'($urandom_range(1)), AW'($urandom_range(15)),
             $urandom, SW'($urandom));
      drain(600);
    end
    dropMode = 1'b0;

`ifdef APB_ARB_TIMEOUT_EN
    // Stuck slave times out; then normal service resumes.
    stuck = 1'b1;
    push(1, 1'b1, 8'h30, 32'h12345678, 4'hF);
    drain(60);
    stuck = 1'b0;
    waitK = 1;
    push(0, 1'b0, 8'h30, 32'h0, 4'h0);
    drain(30);
    waitK = TMO - 1;
    push(2, 1'b0, 8'h10, 32'h0, 4'h0);
    drain(60);
    waitK = TMO;
    push(3, 1'b0, 8'h10, 32'h0, 4'h0);
    drain(60);
    waitK = 1;
`endif

    // Reset during ACCESS: abort, then requester 0 wins first after release.
    waitK = 1;
    push(1, 1'b0, 8'h10, 32'h0, 4'h0);
    drain(30);
    waitK = 6;
    push(2, 1'b0, 8'h10, 32'h0, 4'h0);
    n = 0;
    while (!(psel === 1'b1 && penable === 1'b1) && n < 20) begin step(); n++; end
    chk("reached_access", 64'(psel && penable), 64'(1));
    step();
    applyReset();
    waitK = 1;
    repeat (3) @(negedge pclk);
    for (int i = NREQ - 1; i >= 0; i--) push(i, 1'b0, AW'(8'h10 + i), 32'h0, 4'h0);
    drain(100);

    repeat (4) @(negedge pclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
